bcd_convert_ctrl: RTL

Iterative (shift-and-add-3) binary-to-BCD converter with its own controller.
- Replaces the single-cycle combinational converter where timing is tight. It sequences one digit-adjust/shift step per clock over W cycles.
- Uses a start/ready/done handshake.
- Sits between a binary counter or arithmetic result and the 7-segment display driver.
- Holds the last result stable for the display.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd_convert_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter:
// controller state encoding and output/digit width helpers.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Packed BCD width needed to hold any w-bit binary value.
  function automatic int unsigned bcd_width(input int unsigned w);
    return w + (w - 4) / 3 + 1;
  endfunction

  // Number of 4-bit digits in the internal scratch register.
  function automatic int unsigned bcd_digits(input int unsigned w);
    return (bcd_width(w) + 3) / 4;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit greater than 4
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i > 4'd4) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Iterative shift-and-add-3 binary-to-BCD converter: one adjust/shift step per
// clock over W cycles, start/ready/done handshake, result held between conversions.
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned W = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [W-1:0]           val,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [bcd_width(W)-1:0] bcd
);

  localparam int unsigned BW = bcd_width(W);
  localparam int unsigned ND = bcd_digits(W);
  localparam int unsigned SW = ND * 4;
  localparam int unsigned CW = $clog2(W);

  state_e          state_q, state_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [SW-1:0]   scr_q, scr_d;
  logic [SW-1:0]   scr_adj;
  logic [SW-1:0]   scr_shift;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;

  for (genvar g = 0; g < ND; g++) begin : gen_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (scr_adj[4*g +: 4])
    );
  end

  // Adjusted digits shift left, pulling in the next binary MSB.
  assign scr_shift = {scr_adj[SW-2:0], bin_q[W-1]};

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = val;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        scr_d = scr_shift;
        bin_d = {bin_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_DONE;
          bcd_d   = scr_shift[BW-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_CONV) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign bcd   = bcd_q;

endmodule
